clk_rate_ctrl: RTL

- Run-time controller for the shared divided-clock resource.
- Owns a programmable period counter and sequences its operation: start, stop with drain to period end, and glitch-free divisor reconfiguration at period boundaries.
- Produces a 50%-style `clock_out` enable waveform and a one-cycle `tick` per period for downstream blocks (LED blink, display scan, debouncers).
- Sits between the register/config logic and all rate-driven consumers.

---
 rtl/clk_rate_ctrl_pkg.sv | 14 +
 rtl/clk_rate_cnt.sv | 42 ++++
 rtl/clk_rate_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_rate_ctrl_pkg.sv
// Shared types and constants for the clk_rate_ctrl divided-clock controller.
// Optional tick counter is enabled with the CLK_RATE_CTRL_TICKCNT_EN macro.
package clk_rate_ctrl_pkg;

   localparam int CNT_W_DEF = 28;
   localparam int MIN_DIV   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/clk_rate_cnt.sv
// Period counter for clk_rate_ctrl: counts 0..div-1 while enabled.
// Also decodes the wrap flag, the tick pulse and the clock_out level.
module clk_rate_cnt
   import clk_rate_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] div,
   output logic             wrap,
   output logic             tick,
   output logic             clock_out
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] half_div;

   assign half_div = div >> 1;

   // div only changes at a wrap or while disabled, so cnt_q never exceeds div-1.
   always_comb begin
      wrap      = en && (cnt_q == (div - CNT_W'(1)));
      tick      = en && (cnt_q == '0);
      clock_out = en && (cnt_q < half_div);
      cnt_d     = cnt_q + CNT_W'(1);
      if (!en || wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_rate_ctrl.sv
// Run-time controller for the shared divided clock: start/stop/drain sequencing
// and period-aligned divisor updates. Define CLK_RATE_CTRL_TICKCNT_EN for tick_count.
module clk_rate_ctrl
   import clk_rate_ctrl_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             tick,
   output logic             clock_out,
`ifdef CLK_RATE_CTRL_TICKCNT_EN
   output logic [15:0]      tick_count,
`endif
   output logic             running
);

   localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEFAULT_DIV);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] active_div_q;
   logic [CNT_W-1:0] active_div_d;
   logic [CNT_W-1:0] pend_div_q;
   logic [CNT_W-1:0] pend_div_d;
   logic             pend_valid_q;
   logic             pend_valid_d;
   logic             cfg_err_q;
   logic             cfg_err_d;
   logic [CNT_W-1:0] cfg_div_clamped;
   logic             accept;
   logic             wrap;
   logic             run_req;
   logic             going_idle;

   assign running   = (state_q != IDLE);
   assign cfg_ready = !pend_valid_q;
   assign cfg_err   = cfg_err_q;

   clk_rate_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk      (clock_in),
      .reset    (reset),
      .en       (running),
      .div      (active_div_q),
      .wrap     (wrap),
      .tick     (tick),
      .clock_out(clock_out)
   );

   always_comb begin
      accept          = cfg_valid && !pend_valid_q;
      run_req         = start && !stop;
      cfg_div_clamped = (cfg_div < MIN_DIV_W) ? MIN_DIV_W : cfg_div;
      going_idle      = (state_q == DRAIN) && wrap && !run_req;
      state_d         = state_q;
      active_div_d    = active_div_q;
      pend_div_d      = pend_div_q;
      pend_valid_d    = pend_valid_q;
      cfg_err_d       = accept && (cfg_div < MIN_DIV_W);

      case (state_q)
         IDLE: begin
            if (run_req) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (run_req) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A divisor taken on the final drain wrap has no period left to wait for.
      if (state_q == IDLE || going_idle) begin
         if (pend_valid_q && going_idle) begin
            active_div_d = pend_div_q;
            pend_valid_d = 1'b0;
         end
         if (accept) begin
            active_div_d = cfg_div_clamped;
         end
      end else begin
         if (wrap && pend_valid_q) begin
            active_div_d = pend_div_q;
            pend_valid_d = 1'b0;
         end
         if (accept) begin
            pend_div_d   = cfg_div_clamped;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q      <= IDLE;
         active_div_q <= DEF_DIV_W;
         pend_div_q   <= '0;
         pend_valid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_div_q <= active_div_d;
         pend_div_q   <= pend_div_d;
         pend_valid_q <= pend_valid_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

`ifdef CLK_RATE_CTRL_TICKCNT_EN
   logic [15:0] tick_count_q;
   logic [15:0] tick_count_d;

   always_comb begin
      tick_count_d = tick_count_q;
      if (state_q == IDLE && state_d == RUN) begin
         tick_count_d = '0;
      end else if (tick) begin
         tick_count_d = tick_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         tick_count_q <= '0;
      end else begin
         tick_count_q <= tick_count_d;
      end
   end

   assign tick_count = tick_count_q;
`endif

endmodule
